// File: rtl/aes_pkg.sv
// Shared AES types, constants and the GF(2^8) multiply used by the S-box.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  localparam logic [8:0] AES_POLY      = 9'h11B;
  localparam byte_t      SBOX_AFFINE_C = 8'h63;

  // GF(2^8) multiply, reducing modulo AES_POLY as each partial product is shifted.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ AES_POLY[7:0]) : {t[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_subbytes_if.sv
// Start/state/done bundle between the round datapath and the SubBytes stage.
interface aes_subbytes_if;
  import aes_pkg::*;

  logic   start;
  state_t state_in;
  state_t state_out;
  logic   done;

  modport master (output start, output state_in, input state_out, input done);
  modport slave  (input start, input state_in, output state_out, output done);
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box for one byte.
// Build option AES_SBOX_LUT_EN: constant FIPS-197 table instead of computed inverse+affine.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t i_byte,
  output byte_t o_byte
);

`ifdef AES_SBOX_LUT_EN
  logic [127:0] w_row;

  // Select the 16-entry table row by the high nibble, then the entry by the low nibble.
  always_comb begin
    w_row = '0;
    case (i_byte[7:4])
      4'h0: w_row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: w_row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: w_row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: w_row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: w_row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: w_row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: w_row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: w_row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: w_row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: w_row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: w_row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: w_row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: w_row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: w_row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: w_row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: w_row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
  end

  // Entry 0 of each row sits in the most significant byte.
  assign o_byte = w_row[8*(15 - int'(i_byte[3:0])) +: 8];
`else
  byte_t w_inv;

  // x^254 = x^-1 in GF(2^8) (0 maps to 0): square-and-multiply through x^3, x^7, ... x^127.
  function automatic byte_t gf_inv(input byte_t x);
    byte_t r;
    r = gf_mul(x, x);
    for (int k = 0; k < 6; k++) begin
      r = gf_mul(r, x);
      r = gf_mul(r, r);
    end
    return r;
  endfunction

  // Affine step: XOR of the byte with its left rotations by 1..4, plus the constant.
  function automatic byte_t affine(input byte_t b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ SBOX_AFFINE_C;
  endfunction

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = affine(w_inv);
`endif

endmodule

// File: rtl/aes_subbytes.sv
// AES SubBytes: 16 parallel S-boxes feeding one registered stage with a start/done pulse.
// Build option AES_SBOX_LUT_EN selects the table-based S-box (see aes_sbox).
module aes_subbytes
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  aes_subbytes_if.slave  bus
);

  state_t w_sub;
  state_t r_state_p1;
  logic   r_vld_p1;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (bus.state_in[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  // Stage p1: capture substituted state on start; done follows start by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= bus.start;
      if (bus.start) r_state_p1 <= w_sub;
    end
  end

  assign bus.state_out = r_state_p1;
  assign bus.done      = r_vld_p1;

endmodule

// File: tb/tb_aes_subbytes.sv
// Self-checking bench for aes_subbytes against a brute-force GF(2^8) S-box model.
module tb_aes_subbytes;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  logic [7:0] sbox_tab [256];

  aes_subbytes_if u_if ();

  aes_subbytes u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full polynomial product, then long-division reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // Inverse found by search; affine built bit by bit from its defining equation.
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] r;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
           ^ inv[(i + 7) % 8] ^ c[i];
    return r;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[s[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge where the result should be visible.
  task automatic apply(input logic [127:0] s);
    @(negedge clk);
    u_if.start    = 1'b1;
    u_if.state_in = s;
    @(negedge clk);
    u_if.start    = 1'b0;
    u_if.state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    logic [127:0] fips_in;
    logic [127:0] fips_out;
    logic [127:0] exp_out;
    logic [127:0] rs;
    logic [127:0] p_state;
    logic         p_start;
    logic [7:0]   spot_in  [3];
    logic [7:0]   spot_out [3];

    n_checks = 0;
    n_err    = 0;
    fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    fips_out = 128'hd42711aee0bf98f1b8b45de51e415230;
    spot_in  = '{8'h01, 8'h53, 8'hff};
    spot_out = '{8'h7c, 8'hed, 8'h16};
    for (int v = 0; v < 256; v++) sbox_tab[v] = ref_sbox(8'(v));

    rst_n         = 1'b0;
    u_if.start    = 1'b0;
    u_if.state_in = '0;
    #1;
    chk("reset_done", {127'b0, u_if.done}, 128'h0);
    chk("reset_out", u_if.state_out, 128'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_done", {127'b0, u_if.done}, 128'h0);
    end

    apply(128'h0);
    chk("zero_done", {127'b0, u_if.done}, 128'h1);
    chk("zero_out", u_if.state_out, {16{8'h63}});
    @(negedge clk);
    chk("zero_done_drop", {127'b0, u_if.done}, 128'h0);
    chk("zero_hold", u_if.state_out, {16{8'h63}});

    apply(fips_in);
    chk("fips_done", {127'b0, u_if.done}, 128'h1);
    chk("fips_out", u_if.state_out, fips_out);
    @(negedge clk);
    chk("fips_done_drop", {127'b0, u_if.done}, 128'h0);
    chk("fips_hold", u_if.state_out, fips_out);

    for (int k = 0; k < 3; k++) begin
      apply({120'h0, spot_in[k]});
      chk("spot_out", u_if.state_out, {{15{8'h63}}, spot_out[k]});
    end

    @(negedge clk);
    u_if.start    = 1'b1;
    u_if.state_in = 128'h0;
    @(negedge clk);
    chk("b2b_done0", {127'b0, u_if.done}, 128'h1);
    chk("b2b_out0", u_if.state_out, {16{8'h63}});
    u_if.state_in = fips_in;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("b2b_done1", {127'b0, u_if.done}, 128'h1);
    chk("b2b_out1", u_if.state_out, fips_out);
    @(negedge clk);
    chk("b2b_done_drop", {127'b0, u_if.done}, 128'h0);

    for (int i = 0; i < 20; i++) begin
      rs = {$urandom(), $urandom(), $urandom(), $urandom()};
      apply(rs);
      chk("rand_out", u_if.state_out, sub_ref(rs));
    end
    exp_out = sub_ref(rs);

    p_start = 1'b0;
    p_state = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (p_start) exp_out = sub_ref(p_state);
        chk("stream_done", {127'b0, u_if.done}, {127'b0, p_start});
        chk("stream_out", u_if.state_out, exp_out);
      end
      p_start       = 1'($urandom() % 2);
      p_state       = {$urandom(), $urandom(), $urandom(), $urandom()};
      u_if.start    = p_start;
      u_if.state_in = p_state;
    end
    @(negedge clk);
    u_if.start = 1'b0;
    if (p_start) exp_out = sub_ref(p_state);
    chk("stream_done_last", {127'b0, u_if.done}, {127'b0, p_start});
    chk("stream_out_last", u_if.state_out, exp_out);

    for (int v = 0; v < 256; v++) begin
      apply({16{8'(v)}});
      chk("exh_done", {127'b0, u_if.done}, 128'h1);
      chk("exh_out", u_if.state_out, {16{sbox_tab[v]}});
    end

    apply(fips_in);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_done", {127'b0, u_if.done}, 128'h0);
    chk("async_rst_out", u_if.state_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    u_if.start    = 1'b1;
    u_if.state_in = fips_in;
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("pending_drop_done", {127'b0, u_if.done}, 128'h0);
    chk("pending_drop_out", u_if.state_out, 128'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_done", {127'b0, u_if.done}, 128'h0);
      chk("post_rst_out", u_if.state_out, 128'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/aes_subbytes.md
Name: aes_subbytes

Overview:
- AES SubBytes stage: applies the FIPS-197 forward S-box independently to each of the 16 bytes of a 128-bit state.
- Single registered stage with a start/done pulse handshake.
- Instantiated by the AES round datapath between AddRoundKey and ShiftRows.

Parameters:
- None. Width is fixed at 128 bits (16 bytes).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, active-low, asynchronous
- start  input  1  one-cycle pulse; state_in is valid in this cycle
- state_in  input  128  input state; byte i = state_in[8*i+7:8*i], i=0..15
- state_out  output  128  substituted state, registered; byte i = Sbox(state_in byte i)
- done  output  1  one-cycle pulse; state_out is valid from this cycle

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state_out = 128'h0, done = 0. rst_n asserted mid-operation clears both immediately, and any pending result is discarded.
- Byte mapping: each byte is processed independently and in place. There is no byte reordering.
- S-box: Sbox(x) = Affine(Inv(x)).
  - Inv is the multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1, with Inv(0)=0.
  - Affine: b'_i = b_i ^ b_(i+4 mod 8) ^ b_(i+5 mod 8) ^ b_(i+6 mod 8) ^ b_(i+7 mod 8) ^ c_i, with c = 8'h63.
- Latency: exactly 1 cycle.
  - On the rising edge where start=1, state_out <= Sbox applied to all 16 bytes of state_in, and done <= 1.
  - On any edge where start=0, done <= 0 and state_out holds its value.
- Throughput: one state per cycle. Back-to-back start pulses produce back-to-back done pulses, each with its own result. There is no busy state and no backpressure.
- state_in is ignored when start=0.
- state_out holds the last result indefinitely until the next start or reset.
- The S-box computation is purely combinational from state_in. The only state elements are the 128-bit output register and done.

Optional Feature:
- Macro: AES_SBOX_LUT_EN
- Defined: each S-box is implemented as a 256-entry constant lookup table (case statement with FIPS-197 values).
- Undefined (default): each S-box is computed as GF(2^8) inversion (x^254 by square-and-multiply, or tower-field) followed by the affine transform.
- Port behaviour, latency and results must be bit-identical in both builds.

Decomposition:
- Package aes_pkg:
  - type state_t (logic [127:0])
  - type byte_t (logic [7:0])
  - constant AES_POLY = 9'h11B
  - constant SBOX_AFFINE_C = 8'h63
  - function gf_mul(byte_t, byte_t) for GF(2^8) multiply.
- Sub-module aes_sbox: combinational 8-bit in, 8-bit out, containing the AES_SBOX_LUT_EN selection. aes_subbytes instantiates it 16 times via generate.

Test Plan:
- Reset: assert rst_n=0 with done and state_out previously nonzero -> both read 0 immediately (asynchronous). Release, idle 5 cycles -> done stays 0.
- All-zero: start pulse with state_in = 128'h0 -> next cycle done=1, state_out = {16{8'h63}}; the following cycle done=0 and state_out is held.
- FIPS-197 round 1: state_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808 -> state_out = 128'hd42711aee0bf98f1b8b45de51e415230, done pulses once.
- Byte spot checks, with byte 0 = x and the other bytes 0:
  - x=8'h01 -> 8'h7c
  - x=8'h53 -> 8'hed
  - x=8'hff -> 8'h16
  - other bytes read 8'h63.
- Back-to-back: start high for 2 consecutive cycles, first with all-zero then with the FIPS vector -> done high for 2 consecutive cycles, with the matching results in order.
- Exhaustive: for every byte value v=0..255, state_in = {16{v}} -> every output byte equals the FIPS-197 S-box entry for v. Run under both AES_SBOX_LUT_EN settings.
